// File: rtl/fft_result_streamer.sv
// fft_result_streamer: streams FFT result bins from the core read port as valid/ready beats
// Optional feature: define FFT_STREAM_MAG_EN to add m_mag = re*re + im*im to every beat.
// Ports:
//    clk, rst                 clock, synchronous active-high reset
//    flag_fftfinish           core done level; a rising edge in IDLE starts a frame
//    read_addr                registered core read address (k, or bitrev(k) when BITREV=1)
//    dataout_re, dataout_im   core result words, valid RD_LAT cycles after read_addr
//    m_valid, m_ready         output handshake
//    m_re, m_im, m_idx, m_last  beat payload from the FIFO head
//    m_mag                    squared magnitude of the beat (FFT_STREAM_MAG_EN only)
//    busy                     frame in progress
//    frame_drop               one-cycle pulse when a start edge arrives while busy
module fft_result_streamer #(
   parameter int N          = 8,
   parameter int ADDR_W     = 3,
   parameter int DATA_W     = 24,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4,
   parameter bit BITREV     = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flag_fftfinish,
   output logic [ADDR_W-1:0] read_addr,
   input  logic [DATA_W-1:0] dataout_re,
   input  logic [DATA_W-1:0] dataout_im,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_re,
   output logic [DATA_W-1:0] m_im,
   output logic [ADDR_W-1:0] m_idx,
   output logic              m_last,
`ifdef FFT_STREAM_MAG_EN
   output logic [2*DATA_W:0] m_mag,
`endif
   output logic              busy,
   output logic              frame_drop
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [1:0]              state_q, state_d;
   logic [ADDR_W-1:0]       k_q, k_d, addr_q, addr_d;
   logic                    prev_q, prev_d, armed_q, armed_d, drop_q, drop_d;
   logic [RD_LAT:0]         v_q, v_d, last_q, last_d;
   logic [RD_LAT:0][ADDR_W-1:0] idx_q, idx_d;
   logic [PW-1:0]           wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [31:0]             occ;
   logic                    rise, pop, wr, issue;
   logic [DATA_W-1:0]       mem_re [FIFO_DEPTH];
   logic [DATA_W-1:0]       mem_im [FIFO_DEPTH];
   logic [ADDR_W-1:0]       mem_idx [FIFO_DEPTH];
   logic                    mem_last [FIFO_DEPTH];

   function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
      for (int i = 0; i < ADDR_W; i++) bitrev[i] = a[ADDR_W-1-i];
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      // armed_q blocks a start on the first cycle after reset so a flag held high through reset is not an edge
      rise    = armed_q && flag_fftfinish && !prev_q;
      pop     = m_valid && m_ready;
      wr      = v_q[RD_LAT];
      // credit: everything issued but not yet popped must fit in the FIFO
      occ     = 32'(cnt_q);
      for (int i = 0; i <= RD_LAT; i++) occ = occ + 32'(v_q[i]);
      issue   = (state_q == S_ISSUE) && (occ < FIFO_DEPTH);
      state_d = state_q;
      k_d     = k_q;
      addr_d  = addr_q;
      if (state_q == S_IDLE && rise) begin
         state_d = S_ISSUE;
         k_d     = '0;
      end
      if (issue) begin
         addr_d  = BITREV ? bitrev(k_q) : k_q;
         k_d     = k_q + ADDR_W'(1);
         state_d = (k_q == ADDR_W'(N - 1)) ? S_DRAIN : state_q;
      end
      if (state_q == S_DRAIN && !(|v_q) && (cnt_q == '0 || (cnt_q == CW'(1) && pop))) state_d = S_IDLE;
      drop_d    = rise && (state_q != S_IDLE);
      prev_d    = flag_fftfinish;
      armed_d   = 1'b1;
      // tag pipe: stage 0 lines up with read_addr, stage RD_LAT with the returned data
      v_d[0]    = issue;
      idx_d[0]  = k_q;
      last_d[0] = (k_q == ADDR_W'(N - 1));
      for (int i = 1; i <= RD_LAT; i++) begin
         v_d[i]    = v_q[i-1];
         idx_d[i]  = idx_q[i-1];
         last_d[i] = last_q[i-1];
      end
      cnt_d = cnt_q + CW'(wr) - CW'(pop);
      wp_d  = wr ? ptr_inc(wp_q) : wp_q;
      rp_d  = pop ? ptr_inc(rp_q) : rp_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         addr_q  <= '0;
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
         drop_q  <= 1'b0;
         v_q     <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         addr_q  <= addr_d;
         prev_q  <= prev_d;
         armed_q <= armed_d;
         drop_q  <= drop_d;
         v_q     <= v_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
      end
   end

   // tag payload and FIFO storage are qualified by v_q / cnt_q, so they carry no reset
   always_ff @(posedge clk) begin
      idx_q  <= idx_d;
      last_q <= last_d;
      if (wr) begin
         mem_re[wp_q]   <= dataout_re;
         mem_im[wp_q]   <= dataout_im;
         mem_idx[wp_q]  <= idx_q[RD_LAT];
         mem_last[wp_q] <= last_q[RD_LAT];
      end
   end

`ifdef FFT_STREAM_MAG_EN
   logic [2*DATA_W-1:0] re_x, im_x, re_sq, im_sq;
   logic [2*DATA_W:0]   mem_mag [FIFO_DEPTH];
   always_comb begin
      re_x  = {{DATA_W{dataout_re[DATA_W-1]}}, dataout_re};
      im_x  = {{DATA_W{dataout_im[DATA_W-1]}}, dataout_im};
      re_sq = re_x * re_x;
      im_sq = im_x * im_x;
   end
   always_ff @(posedge clk) begin
      if (wr) mem_mag[wp_q] <= {1'b0, re_sq} + {1'b0, im_sq};
   end
   assign m_mag = m_valid ? mem_mag[rp_q] : '0;
`endif

   assign read_addr  = addr_q;
   assign m_valid    = (cnt_q != '0);
   assign m_re       = m_valid ? mem_re[rp_q] : '0;
   assign m_im       = m_valid ? mem_im[rp_q] : '0;
   assign m_idx      = m_valid ? mem_idx[rp_q] : '0;
   assign m_last     = m_valid && mem_last[rp_q];
   assign busy       = (state_q != S_IDLE);
   assign frame_drop = drop_q;
endmodule

// File: tb/tb_fft_result_streamer.sv
// tb_fft_result_streamer: directed self-checking bench for fft_result_streamer
module tb_fft_result_streamer;
   localparam int DW = 24;
   logic clk = 1'b0, rst = 1'b1, flag = 1'b0, m_ready = 1'b0, flag_br = 1'b0, ready_br = 1'b1;
   logic [2:0] read_addr, read_addr_br, m_idx, m_idx_br;
   logic [DW-1:0] dre, dim, dre_br, dim_br, m_re, m_im, m_re_br, m_im_br;
   logic m_valid, m_last, busy, frame_drop, m_valid_br, m_last_br, busy_br, frame_drop_br;
`ifdef FFT_STREAM_MAG_EN
   logic [2*DW:0] m_mag, m_mag_br;
`endif
   logic [DW-1:0] tab_re [8];
   logic [DW-1:0] tab_im [8];
   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   // core model with one cycle of read latency
   always @(posedge clk) begin
      dre    <= tab_re[read_addr];
      dim    <= tab_im[read_addr];
      dre_br <= tab_re[read_addr_br];
      dim_br <= tab_im[read_addr_br];
   end

   fft_result_streamer #(.N(8), .ADDR_W(3), .DATA_W(DW), .RD_LAT(1), .FIFO_DEPTH(4), .BITREV(0)) dut (
      .clk(clk), .rst(rst), .flag_fftfinish(flag), .read_addr(read_addr),
      .dataout_re(dre), .dataout_im(dim), .m_valid(m_valid), .m_ready(m_ready),
      .m_re(m_re), .m_im(m_im), .m_idx(m_idx), .m_last(m_last),
`ifdef FFT_STREAM_MAG_EN
      .m_mag(m_mag),
`endif
      .busy(busy), .frame_drop(frame_drop));

   fft_result_streamer #(.N(8), .ADDR_W(3), .DATA_W(DW), .RD_LAT(1), .FIFO_DEPTH(4), .BITREV(1)) dut_br (
      .clk(clk), .rst(rst), .flag_fftfinish(flag_br), .read_addr(read_addr_br),
      .dataout_re(dre_br), .dataout_im(dim_br), .m_valid(m_valid_br), .m_ready(ready_br),
      .m_re(m_re_br), .m_im(m_im_br), .m_idx(m_idx_br), .m_last(m_last_br),
`ifdef FFT_STREAM_MAG_EN
      .m_mag(m_mag_br),
`endif
      .busy(busy_br), .frame_drop(frame_drop_br));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; flag = 1'b0; m_ready = 1'b0;
      repeat (3) tick();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got=%0b exp=0", m_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      checks++; if (read_addr !== 3'd0) begin errors++; $display("FAIL reset_read_addr got=%0d exp=0", read_addr); end
      checks++; if ({frame_drop, m_last, m_idx, m_re, m_im} !== 53'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", {frame_drop, m_last, m_idx, m_re, m_im}); end
      rst = 1'b0;
      repeat (2) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%0b exp=0", busy); end
   endtask

   task automatic test_stream;
      logic [52:0] exp_b;
      m_ready = 1'b1; flag = 1'b1;
      tick();
      checks++; if ({busy, m_valid} !== 2'b10) begin errors++; $display("FAIL stream_t0 busy,valid got=%b exp=10", {busy, m_valid}); end
      tick();
      checks++; if (read_addr !== 3'd0) begin errors++; $display("FAIL stream_first_addr got=%0d exp=0", read_addr); end
      flag = 1'b0;
      tick();
      checks++; if ({m_valid, read_addr} !== 4'b0001) begin errors++; $display("FAIL stream_t2 valid,addr got=%b exp=0001", {m_valid, read_addr}); end
      for (int j = 0; j < 8; j++) begin
         tick();
         exp_b = {1'b1, 3'(j), 24'(100 + j), 24'(-j), j == 7};
         checks++; if ({m_valid, m_idx, m_re, m_im, m_last} !== exp_b) begin errors++; $display("FAIL stream_beat%0d got=%h exp=%h", j, {m_valid, m_idx, m_re, m_im, m_last}, exp_b); end
      end
      tick();
      checks++; if ({busy, m_valid, frame_drop} !== 3'b000) begin errors++; $display("FAIL stream_end busy,valid,drop got=%b exp=000", {busy, m_valid, frame_drop}); end
   endtask

   task automatic test_backpressure;
      int acc = 0;
      logic stalled = 1'b0;
      logic [52:0] cur_b, prev_b, exp_b;
      prev_b = '0;
      m_ready = 1'b1; flag = 1'b1;
      tick();
      flag = 1'b0;
      for (int c = 1; c <= 60 && acc < 8; c++) begin
         tick();
         cur_b = {m_valid, m_idx, m_re, m_im, m_last};
         if (stalled) begin
            checks++; if (cur_b !== prev_b) begin errors++; $display("FAIL bp_stable cyc%0d got=%h exp=%h", c, cur_b, prev_b); end
         end
         checks++; if (int'(read_addr) + 1 - acc > 4) begin errors++; $display("FAIL bp_outstanding cyc%0d got=%0d exp<=4", c, int'(read_addr) + 1 - acc); end
         m_ready = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
         if (m_valid && m_ready) begin
            exp_b = {1'b1, 3'(acc), 24'(100 + acc), 24'(-acc), acc == 7};
            checks++; if (cur_b !== exp_b) begin errors++; $display("FAIL bp_beat%0d got=%h exp=%h", acc, cur_b, exp_b); end
            acc++;
         end
         stalled = m_valid && !m_ready;
         prev_b = cur_b;
      end
      checks++; if (acc != 8) begin errors++; $display("FAIL bp_beat_count got=%0d exp=8", acc); end
      m_ready = 1'b1;
      tick();
      checks++; if ({busy, m_valid} !== 2'b00) begin errors++; $display("FAIL bp_end busy,valid got=%b exp=00", {busy, m_valid}); end
   endtask

   task automatic test_bitrev;
      int br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
      logic [52:0] exp_b;
      flag_br = 1'b1;
      tick();
      flag_br = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         tick();
         if (c <= 8) begin
            checks++; if (read_addr_br !== 3'(br[c-1])) begin errors++; $display("FAIL bitrev_addr%0d got=%0d exp=%0d", c - 1, read_addr_br, br[c-1]); end
         end
         if (c >= 3 && c <= 10) begin
            exp_b = {1'b1, 3'(c - 3), 24'(100 + br[c-3]), 24'(-br[c-3]), c == 10};
            checks++; if ({m_valid_br, m_idx_br, m_re_br, m_im_br, m_last_br} !== exp_b) begin errors++; $display("FAIL bitrev_beat%0d got=%h exp=%h", c - 3, {m_valid_br, m_idx_br, m_re_br, m_im_br, m_last_br}, exp_b); end
         end
      end
      checks++; if (busy_br !== 1'b0) begin errors++; $display("FAIL bitrev_end_busy got=%0b exp=0", busy_br); end
   endtask

   task automatic test_frame_drop;
      int n = 0;
      logic [52:0] exp_b;
      m_ready = 1'b1; flag = 1'b1;
      tick();
      for (int c = 1; c <= 12; c++) begin
         tick();
         checks++; if (frame_drop !== (c == 7)) begin errors++; $display("FAIL drop_pulse cyc%0d got=%0b exp=%0b", c, frame_drop, c == 7); end
         if (c >= 3 && c <= 10) begin
            exp_b = {1'b1, 3'(c - 3), 24'(97 + c), 24'(3 - c), c == 10};
            checks++; if ({m_valid, m_idx, m_re, m_im, m_last} !== exp_b) begin errors++; $display("FAIL drop_beat%0d got=%h exp=%h", c - 3, {m_valid, m_idx, m_re, m_im, m_last}, exp_b); end
         end
         if (c == 1) flag = 1'b0;
         if (c == 6) flag = 1'b1;
      end
      repeat (4) tick();
      checks++; if ({busy, m_valid} !== 2'b00) begin errors++; $display("FAIL drop_no_second_frame busy,valid got=%b exp=00", {busy, m_valid}); end
      flag = 1'b0;
      tick();
      flag = 1'b1;
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_new_frame_busy got=%0b exp=1", busy); end
      flag = 1'b0;
      for (int c = 0; c < 20 && n < 8; c++) begin
         tick();
         if (m_valid) n++;
      end
      checks++; if (n != 8) begin errors++; $display("FAIL drop_new_frame_beats got=%0d exp=8", n); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_new_frame_end got=%0b exp=0", busy); end
   endtask

   task automatic test_reset_mid;
      int n = 0;
      m_ready = 1'b1; flag = 1'b1;
      tick();
      repeat (7) tick();
      checks++; if ({m_valid, m_idx} !== 4'b1100) begin errors++; $display("FAIL rstmid_pre valid,idx got=%b exp=1100", {m_valid, m_idx}); end
      rst = 1'b1;
      tick();
      checks++; if ({m_valid, busy, m_last, read_addr} !== 6'd0) begin errors++; $display("FAIL rstmid_after valid,busy,last,addr got=%b exp=000000", {m_valid, busy, m_last, read_addr}); end
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++; if ({busy, m_valid} !== 2'b00) begin errors++; $display("FAIL rstmid_flag_high cyc%0d busy,valid got=%b exp=00", c, {busy, m_valid}); end
      end
      flag = 1'b0;
      tick();
      flag = 1'b1;
      tick();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_restart_busy got=%0b exp=1", busy); end
      flag = 1'b0;
      for (int c = 0; c < 20 && n < 8; c++) begin
         tick();
         if (m_valid) begin
            checks++; if ({m_idx, m_last} !== {3'(n), n == 7}) begin errors++; $display("FAIL rstmid_beat%0d idx,last got=%b exp=%b", n, {m_idx, m_last}, {3'(n), n == 7}); end
            n++;
         end
      end
      checks++; if (n != 8) begin errors++; $display("FAIL rstmid_beats got=%0d exp=8", n); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_end_busy got=%0b exp=0", busy); end
   endtask

`ifdef FFT_STREAM_MAG_EN
   task automatic test_mag;
      int seen = 0;
      tab_re[2] = 24'd3; tab_im[2] = -24'sd4;
      tab_re[5] = 24'h800000; tab_im[5] = 24'd0;
      m_ready = 1'b1; flag = 1'b1;
      tick();
      flag = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         tick();
         if (m_valid && m_idx == 3'd2) begin
            seen++;
            checks++; if (m_mag !== 49'd25) begin errors++; $display("FAIL mag_bin2 got=%0d exp=25", m_mag); end
         end
         if (m_valid && m_idx == 3'd5) begin
            seen++;
            checks++; if (m_mag !== 49'd70368744177664) begin errors++; $display("FAIL mag_bin5 got=%0d exp=70368744177664", m_mag); end
         end
      end
      checks++; if (seen != 2) begin errors++; $display("FAIL mag_beats_seen got=%0d exp=2", seen); end
      tab_re[2] = 24'd102; tab_im[2] = -24'sd2;
      tab_re[5] = 24'd105; tab_im[5] = -24'sd5;
   endtask
`endif

   initial begin
      for (int a = 0; a < 8; a++) begin
         tab_re[a] = 24'(100 + a);
         tab_im[a] = 24'(-a);
      end
      test_reset();
      test_stream();
      test_backpressure();
      test_bitrev();
      test_frame_drop();
      test_reset_mid();
`ifdef FFT_STREAM_MAG_EN
      test_mag();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
